exec_pipe: RTL and testbench
============================

EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 The block SHALL expose these ports, one clock; reset is synchronous and active-low:
  Clk  in  1  rising-edge clock
  ResetN  in  1  synchronous active-low reset
  Stall  in  1  ID hazard stall; insert bubble into ID/EX
  ALUSrc  in  1  0 = DataB operand, 1 = SignExtend operand
  ALUControl  in  3  ALU operation
  MemRead, MemWrite, RegWrite  in  1 each  ID control bits
  DataA, DataB, SignExtend  in  32 each  forwarded operands, immediate
  Rs, Rt, Rd  in  5 each  register specifiers
  EXRegWrite, EXMemRead  out  1 each  ID/EX-stage hazard info
  EXRd  out  5  EX-stage destination
  MEMRegWrite  out  1;  MEMData  out  32;  MEMRd  out  5  MEM-stage forward
  WBRegWrite  out  1;  WBData  out  32;  WBRd  out  5  register-file write port

Function
REQ-002 Three pipeline registers SHALL exist (ID/EX, EX/MEM, MEM/WB), all updated on the rising Clk edge.
REQ-003 ID/EX SHALL capture all ID inputs each edge; with Stall=1 it SHALL capture a bubble: RegWrite, MemRead, MemWrite = 0 and Dest = 0.
REQ-004 Dest SHALL be Rt when ALUSrc=1, else Rd; a Dest of 0 SHALL force the stage's RegWrite to 0.
REQ-005 ALU (EX stage, combinational from ID/EX): 000 AND, 001 OR, 010 ADD, 110 SUB, 111 signed SLT (result 1/0); other codes yield 0.
REQ-006 ADD/SUB SHALL wrap modulo 2^32; no overflow flag or trap.
REQ-007 EXRegWrite, EXMemRead and EXRd SHALL come directly from ID/EX register contents.
REQ-008 EX/MEM SHALL hold ALU result, store data (ID/EX DataB), Dest, RegWrite, MemRead and MemWrite.
REQ-009 Data memory: 64 x 32-bit words indexed by ALU result [7:2]; address bits [1:0] and [31:8] are ignored.
REQ-010 Memory read SHALL be combinational in MEM; memory write SHALL occur on the edge while EX/MEM MemWrite=1.
REQ-011 MEMData SHALL equal memory read data when EX/MEM MemRead=1, else the EX/MEM ALU result.
REQ-012 MEMRegWrite and MEMRd SHALL come from EX/MEM.
REQ-013 MEM/WB SHALL capture MEMData, Dest and RegWrite; WBData, WBRd and WBRegWrite SHALL be driven from MEM/WB.
REQ-014 Latency: inputs sampled at edge N SHALL appear on EX* after N, on MEM* after N+1, and on WB* after N+2.
REQ-015 MemRead and MemWrite both 1 is illegal; the write SHALL take effect and MEMData SHALL return pre-write data.
REQ-016 Back-to-back Stall cycles SHALL each insert one bubble; instructions already downstream SHALL keep advancing.

Reset
REQ-017 With ResetN=0 at an edge, all three pipeline registers SHALL clear, so every output reads 0 from the next cycle.
REQ-018 Reset mid-operation SHALL discard all in-flight instructions; a store held in EX/MEM at that edge SHALL NOT write memory.
REQ-019 Data memory contents SHALL NOT be reset.

Structure
REQ-020 The ALUControl encodings and the memory depth (64) SHALL be constants in a shared pipeline package.
REQ-021 The ALU SHALL be a separate combinational sub-module named exec_alu.

Verification
REQ-022 Reset: ResetN=0 for one edge -> all outputs 0; with ResetN=1 and zero inputs, outputs stay 0.
REQ-023 ADD: DataA=5, DataB=7, ALUControl=010, RegWrite=1, Rd=3 -> after edge 1 EXRd=3; after edge 2 MEMData=12, MEMRd=3; after edge 3 WBData=12, WBRd=3, WBRegWrite=1.
REQ-024 Store/load: store DataA=0, SignExtend=8, DataB=D00DD00D; next cycle load with MemRead=1, ALUSrc=1, Rt=4, same address -> MEMData=D00DD00D; the edge after, WBRd=4.
REQ-025 Stall: Stall=1 with RegWrite=1, Rd=1 -> after the edge EXRegWrite=0, EXRd=0; the prior instruction continues to MEM unchanged.
REQ-026 SLT and wrap: DataA=FFFFFFFF, DataB=1, ALUControl=111 -> result 1; ALUControl=010 -> result 0; Rd=0 -> RegWrite forced 0.

Source files
------------

// File: rtl/exec_pipe_pkg.sv
// exec_pipe_pkg
// Shared constants for the EX/MEM/WB pipeline slice: datapath and register
// specifier widths, data memory geometry, ALU operation encodings, and the
// destination-select helper used when ID/EX captures an instruction.
package exec_pipe_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int MEM_DEPTH = 64;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Immediate-form instructions write Rt; register-form write Rd.
    function automatic logic [REG_W-1:0] sel_dest(
        input logic             alu_src,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd
    );
        return alu_src ? rt : rd;
    endfunction

endpackage

// File: rtl/exec_pipe_if.sv
// exec_pipe_if
// Bundles the ID-stage inputs and the EX/MEM/WB observation outputs of
// exec_pipe.
//   slave  : the pipeline (consumes ID controls/operands, drives stage info)
//   master : the decode side / environment (drives ID inputs, observes stages)
// ID inputs : Stall, ALUSrc, ALUControl[2:0], MemRead, MemWrite, RegWrite,
//             DataA/DataB/SignExtend[31:0], Rs/Rt/Rd[4:0]
// Outputs   : EXRegWrite, EXMemRead, EXRd[4:0],
//             MEMRegWrite, MEMData[31:0], MEMRd[4:0],
//             WBRegWrite, WBData[31:0], WBRd[4:0]
interface exec_pipe_if;
    import exec_pipe_pkg::*;

    logic              Stall;
    logic              ALUSrc;
    logic [2:0]        ALUControl;
    logic              MemRead;
    logic              MemWrite;
    logic              RegWrite;
    logic [DATA_W-1:0] DataA;
    logic [DATA_W-1:0] DataB;
    logic [DATA_W-1:0] SignExtend;
    logic [REG_W-1:0]  Rs;
    logic [REG_W-1:0]  Rt;
    logic [REG_W-1:0]  Rd;

    logic              EXRegWrite;
    logic              EXMemRead;
    logic [REG_W-1:0]  EXRd;
    logic              MEMRegWrite;
    logic [DATA_W-1:0] MEMData;
    logic [REG_W-1:0]  MEMRd;
    logic              WBRegWrite;
    logic [DATA_W-1:0] WBData;
    logic [REG_W-1:0]  WBRd;

    modport master (
        output Stall, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
               DataA, DataB, SignExtend, Rs, Rt, Rd,
        input  EXRegWrite, EXMemRead, EXRd,
               MEMRegWrite, MEMData, MEMRd,
               WBRegWrite, WBData, WBRd
    );

    modport slave (
        input  Stall, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
               DataA, DataB, SignExtend, Rs, Rt, Rd,
        output EXRegWrite, EXMemRead, EXRd,
               MEMRegWrite, MEMData, MEMRd,
               WBRegWrite, WBData, WBRd
    );

endinterface

// File: rtl/exec_pipe_alu.sv
// exec_alu
// Purely combinational EX-stage ALU.
//   alu_ctl : operation code (AND, OR, ADD, SUB, signed SLT; others give 0)
//   op_a    : first operand
//   op_b    : second operand (register or immediate, selected upstream)
//   result  : operation result; ADD/SUB wrap modulo 2^32
module exec_alu
    import exec_pipe_pkg::*;
(
    input  logic [2:0]               alu_ctl,
    input  logic signed [DATA_W-1:0] op_a,
    input  logic signed [DATA_W-1:0] op_b,
    output logic signed [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_ctl)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            // Both operands are declared signed, so this is a signed compare.
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_pipe.sv
// exec_pipe
// EX, MEM and WB stages of a 5-stage RISC pipeline: ID/EX, EX/MEM and MEM/WB
// registers, the EX-stage ALU, and a 64-word data memory in MEM.
//   Clk    : rising-edge clock
//   ResetN : synchronous active-low reset; clears all pipeline registers
//            (data memory is left untouched)
//   bus    : exec_pipe_if.slave carrying the ID inputs and the EX/MEM/WB
//            hazard, forwarding and register-file write outputs
module exec_pipe
    import exec_pipe_pkg::*;
(
    input  logic       Clk,
    input  logic       ResetN,
    exec_pipe_if.slave bus
);

    logic [REG_W-1:0] id_dest;

    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic signed [DATA_W-1:0] imm_p0;
    logic                     alu_src_p0;
    logic [2:0]               ctl_p0;
    logic                     rw_p0;
    logic                     mr_p0;
    logic                     mw_p0;
    logic [REG_W-1:0]         dest_p0;

    logic signed [DATA_W-1:0] op_b_ex;
    logic signed [DATA_W-1:0] alu_res;

    logic signed [DATA_W-1:0] alu_p1;
    logic [DATA_W-1:0]        store_p1;
    logic [REG_W-1:0]         dest_p1;
    logic                     rw_p1;
    logic                     mr_p1;
    logic                     mw_p1;

    logic [DATA_W-1:0]        mem [MEM_DEPTH];
    logic [MEM_AW-1:0]        mem_idx;
    logic [DATA_W-1:0]        mem_rdata;
    logic [DATA_W-1:0]        mem_data;

    logic [DATA_W-1:0]        data_p2;
    logic [REG_W-1:0]         dest_p2;
    logic                     rw_p2;

    assign id_dest = sel_dest(bus.ALUSrc, bus.Rt, bus.Rd);

    // ---- ID -> EX boundary (ID/EX register) ----
    // A stall keeps the operands but turns the slot into a bubble: no side
    // effects and no destination, so downstream forwarding ignores it.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            a_p0       <= '0;
            b_p0       <= '0;
            imm_p0     <= '0;
            alu_src_p0 <= 1'b0;
            ctl_p0     <= '0;
            rw_p0      <= 1'b0;
            mr_p0      <= 1'b0;
            mw_p0      <= 1'b0;
            dest_p0    <= '0;
        end else begin
            a_p0       <= bus.DataA;
            b_p0       <= bus.DataB;
            imm_p0     <= bus.SignExtend;
            alu_src_p0 <= bus.ALUSrc;
            ctl_p0     <= bus.ALUControl;
            if (bus.Stall) begin
                rw_p0   <= 1'b0;
                mr_p0   <= 1'b0;
                mw_p0   <= 1'b0;
                dest_p0 <= '0;
            end else begin
                // Register 0 is hardwired; never claim a write to it.
                rw_p0   <= bus.RegWrite && (id_dest != '0);
                mr_p0   <= bus.MemRead;
                mw_p0   <= bus.MemWrite;
                dest_p0 <= id_dest;
            end
        end
    end

    assign bus.EXRegWrite = rw_p0;
    assign bus.EXMemRead  = mr_p0;
    assign bus.EXRd       = dest_p0;

    assign op_b_ex = alu_src_p0 ? imm_p0 : b_p0;

    exec_alu u_alu (
        .alu_ctl (ctl_p0),
        .op_a    (a_p0),
        .op_b    (op_b_ex),
        .result  (alu_res)
    );

    // ---- EX -> MEM boundary (EX/MEM register) ----
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            alu_p1   <= '0;
            store_p1 <= '0;
            dest_p1  <= '0;
            rw_p1    <= 1'b0;
            mr_p1    <= 1'b0;
            mw_p1    <= 1'b0;
        end else begin
            alu_p1   <= alu_res;
            store_p1 <= b_p0;
            dest_p1  <= dest_p0;
            rw_p1    <= rw_p0;
            mr_p1    <= mr_p0;
            mw_p1    <= mw_p0;
        end
    end

    // Word-addressed: byte offset and upper address bits are ignored.
    assign mem_idx   = alu_p1[MEM_AW+1:2];
    assign mem_rdata = mem[mem_idx];
    // The read is combinational from current contents, so a slot with both
    // MemRead and MemWrite set returns the value from before its own write.
    assign mem_data  = mr_p1 ? mem_rdata : alu_p1;

    // A store sitting in EX/MEM on a reset edge is discarded, not written.
    always_ff @(posedge Clk) begin
        if (ResetN && mw_p1) begin
            mem[mem_idx] <= store_p1;
        end
    end

    assign bus.MEMRegWrite = rw_p1;
    assign bus.MEMData     = mem_data;
    assign bus.MEMRd       = dest_p1;

    // ---- MEM -> WB boundary (MEM/WB register) ----
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            data_p2 <= '0;
            dest_p2 <= '0;
            rw_p2   <= 1'b0;
        end else begin
            data_p2 <= mem_data;
            dest_p2 <= dest_p1;
            rw_p2   <= rw_p1;
        end
    end

    assign bus.WBRegWrite = rw_p2;
    assign bus.WBData     = data_p2;
    assign bus.WBRd       = dest_p2;

endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe
// Directed testbench for exec_pipe. Each applied instruction is turned into
// a per-instruction record (what it computes, where it goes, what it reads
// from a sparse memory model); the record appears on EX one edge after it is
// sampled, on MEM one edge later and on WB one edge after that. A compare
// process checks all outputs on every falling edge, and literal checks pin
// the hand-computed values of the directed scenarios.
module tb_exec_pipe;

    logic Clk = 1'b0;
    logic ResetN;

    always #5 Clk = ~Clk;

    exec_pipe_if bus ();

    exec_pipe dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] store;
        logic [31:0] memdata;
    } rec_t;

    rec_t        hist [0:511];
    logic [31:0] mem_model [int];
    int          e = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    rec_t        ex_exp;
    rec_t        mem_exp;
    rec_t        wb_exp;

    function automatic logic [31:0] alu_model(input logic [2:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic rec_t at(input int i);
        if (i < 0) return '0;
        return hist[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("EXRegWrite",  32'(bus.EXRegWrite),  32'(ex_exp.rw));
            check("EXMemRead",   32'(bus.EXMemRead),   32'(ex_exp.mr));
            check("EXRd",        32'(bus.EXRd),        32'(ex_exp.dest));
            check("MEMRegWrite", 32'(bus.MEMRegWrite), 32'(mem_exp.rw));
            check("MEMData",     bus.MEMData,          mem_exp.memdata);
            check("MEMRd",       32'(bus.MEMRd),       32'(mem_exp.dest));
            check("WBRegWrite",  32'(bus.WBRegWrite),  32'(wb_exp.rw));
            check("WBData",      bus.WBData,           wb_exp.memdata);
            check("WBRd",        32'(bus.WBRd),        32'(wb_exp.dest));
        end
    end

    // Apply one instruction for one edge, update the model, return at negedge.
    task automatic step(input logic rstn, input logic stall, input logic alusrc,
                        input logic [2:0] ctl, input logic mr, input logic mw,
                        input logic rw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
        rec_t        r;
        logic [31:0] op2;
        logic [5:0]  idx;
        ResetN         = rstn;
        bus.Stall      = stall;
        bus.ALUSrc     = alusrc;
        bus.ALUControl = ctl;
        bus.MemRead    = mr;
        bus.MemWrite   = mw;
        bus.RegWrite   = rw;
        bus.DataA      = a;
        bus.DataB      = b;
        bus.SignExtend = se;
        bus.Rs         = 5'd7;
        bus.Rt         = rt;
        bus.Rd         = rd;
        @(posedge Clk);
        // A reset edge discards everything still in flight.
        if (!rstn) begin
            if (e >= 1) hist[e-1] = '0;
            if (e >= 2) hist[e-2] = '0;
        end
        // The instruction two edges old commits its store on this edge.
        if (rstn && e >= 2 && hist[e-2].mw) begin
            idx = hist[e-2].result[7:2];
            mem_model[int'(idx)] = hist[e-2].store;
        end
        r = '0;
        if (rstn) begin
            r.dest   = alusrc ? rt : rd;
            op2      = alusrc ? se : b;
            r.result = alu_model(ctl, a, op2);
            r.store  = b;
            if (stall) begin
                r.dest = 5'd0;
            end else begin
                r.rw = rw && (r.dest != 5'd0);
                r.mr = mr;
                r.mw = mw;
            end
        end
        hist[e] = r;
        // The instruction now in MEM reads memory as it stands after this edge.
        if (e >= 1) begin
            idx = hist[e-1].result[7:2];
            hist[e-1].memdata = hist[e-1].mr ? mem_model[int'(idx)] : hist[e-1].result;
        end
        ex_exp  = at(e);
        mem_exp = at(e - 1);
        wb_exp  = at(e - 2);
        e++;
        chk_en = 1'b1;
        @(negedge Clk);
    endtask

    task automatic nop();
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) hist[i] = '0;

        // Reset with busy inputs: everything reads zero afterwards.
        step(1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 32'd9, 32'd9, 32'd4, 5'd6, 5'd7);
        check("rst_exrd",   32'(bus.EXRd), 32'd0);
        check("rst_exrw",   32'(bus.EXRegWrite), 32'd0);
        check("rst_wbdata", bus.WBData, 32'd0);
        nop();
        nop();
        check("idle_wbrw",  32'(bus.WBRegWrite), 32'd0);
        check("idle_mem",   bus.MEMData, 32'd0);

        // ADD 5+7 -> r3
        step(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3);
        check("add_exrd", 32'(bus.EXRd), 32'd3);
        nop();
        check("add_memdata", bus.MEMData, 32'd12);
        check("add_memrd",   32'(bus.MEMRd), 32'd3);
        nop();
        check("add_wbdata", bus.WBData, 32'd12);
        check("add_wbrd",   32'(bus.WBRd), 32'd3);
        check("add_wbrw",   32'(bus.WBRegWrite), 32'd1);

        // Store D00DD00D to address 8, then load it into r4.
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0, 32'hD00DD00D, 32'd8, 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd8, 5'd4, 5'd0);
        check("ld_exmr", 32'(bus.EXMemRead), 32'd1);
        nop();
        check("ld_memdata", bus.MEMData, 32'hD00DD00D);
        check("ld_memrd",   32'(bus.MEMRd), 32'd4);
        nop();
        check("ld_wbrd",   32'(bus.WBRd), 32'd4);
        check("ld_wbdata", bus.WBData, 32'hD00DD00D);

        // OR F0|0F -> r2, then two back-to-back stall bubbles.
        step(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'hF0, 32'h0F, 32'd0, 5'd0, 5'd2);
        step(1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 5'd0, 5'd1);
        check("stl_exrw",   32'(bus.EXRegWrite), 32'd0);
        check("stl_exrd",   32'(bus.EXRd), 32'd0);
        check("stl_memdat", bus.MEMData, 32'hFF);
        check("stl_memrd",  32'(bus.MEMRd), 32'd2);
        check("stl_memrw",  32'(bus.MEMRegWrite), 32'd1);
        step(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'd0, 5'd0, 5'd9);
        check("stl2_exrd",  32'(bus.EXRd), 32'd0);
        check("stl2_memrw", 32'(bus.MEMRegWrite), 32'd0);
        check("stl2_wbrd",  32'(bus.WBRd), 32'd2);
        check("stl2_wbdat", bus.WBData, 32'hFF);
        nop();

        // SLT(-1,1), ADD wrap, SUB 3-5, ADD to r0, undefined opcode.
        step(1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 5'd5);
        step(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 5'd6);
        check("slt_memdata", bus.MEMData, 32'd1);
        step(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 5'd0, 5'd7);
        check("wrap_memdata", bus.MEMData, 32'd0);
        check("wrap_memrd",   32'(bus.MEMRd), 32'd6);
        step(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0);
        check("r0_exrw",     32'(bus.EXRegWrite), 32'd0);
        check("sub_memdata", bus.MEMData, 32'hFFFFFFFE);
        step(1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF, 32'hFFFF, 32'd0, 5'd0, 5'd8);
        check("r0_memdata", bus.MEMData, 32'd3);
        check("r0_memrw",   32'(bus.MEMRegWrite), 32'd0);
        nop();
        check("undef_memdata", bus.MEMData, 32'd0);

        // Store 11111111 @16; read+write 22222222 @16; load @16.
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0, 32'h11111111, 32'd16, 5'd0, 5'd0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 32'd0, 32'h22222222, 32'd16, 5'd10, 5'd0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd16, 5'd11, 5'd0);
        check("rw_memdata", bus.MEMData, 32'h11111111);
        nop();
        check("rw_after", bus.MEMData, 32'h22222222);
        nop();
        nop();

        // Store 44444444 @20; store 33333333 @20 killed by a reset edge.
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0, 32'h44444444, 32'd20, 5'd0, 5'd0);
        nop();
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0, 32'h33333333, 32'd20, 5'd0, 5'd0);
        nop();
        step(1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h5, 32'h5, 32'd0, 5'd0, 5'd3);
        check("mrst_memdata", bus.MEMData, 32'd0);
        check("mrst_wbdata",  bus.WBData, 32'd0);
        check("mrst_exrd",    32'(bus.EXRd), 32'd0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd20, 5'd12, 5'd0);
        nop();
        check("mrst_load", bus.MEMData, 32'h44444444);
        nop();
        check("mrst_wb", bus.WBData, 32'h44444444);
        nop();

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
